// File: rtl/enable_seq_pkg.sv
// Shared types for the enable-pattern sequencer: FSM states and the queued
// command record.
package enable_seq_pkg;

  // Duration field width carried by every queued command.
  localparam int SEQ_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic                 level;
    logic [SEQ_CNT_W-1:0] cycles;
  } seq_cmd_t;

endpackage

// File: rtl/enable_seq_if.sv
// Command port of the enable sequencer: valid/ready handshake carrying one
// {level, cycles} command per accepted beat.
interface enable_seq_if
  import enable_seq_pkg::*;
#(
  parameter int CNT_W = SEQ_CNT_W
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_level;
  logic [CNT_W-1:0] cmd_cycles;

  modport master (
    output cmd_valid,
    output cmd_level,
    output cmd_cycles,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_level,
    input  cmd_cycles,
    output cmd_ready
  );

endinterface

// File: rtl/enable_seq_cmd_fifo.sv
// Small command FIFO: power-of-two depth, head data visible with no read
// latency, flush has priority over push and pop.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 17
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Guard the pointers against overflow/underflow even if the caller misbehaves.
  assign do_push_s = push && !full && !flush;
  assign do_pop_s  = pop && !empty && !flush;

  assign full      = (count_r == CNT_MAX);
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign head_data = mem_r[rd_ptr_r];

  // Storage array: written at the tail on an accepted push.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/enable_seq.sv
// Enable-pattern sequencer: plays queued {level, cycles} commands onto the
// bus enable, back to back, and pulses done once the queue runs dry.
module enable_seq
  import enable_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  // Must equal SEQ_CNT_W: the queued command record is sized by the package.
  parameter int CNT_W = SEQ_CNT_W
) (
  input  logic                       clk,
  input  logic                       rstn,
  enable_seq_if.slave                cmd,
  input  logic                       start,
  input  logic                       abort,
  output logic                       enable,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  seq_state_t     state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic           enable_r, enable_s;
  logic           busy_r, busy_s;
  logic           done_r, done_s;
  logic           push_s, pop_s;
  logic           full_s, empty_s;
  seq_cmd_t       push_cmd_s, head_cmd_s;
  logic [CW-1:0]  count_s;

  // A zero duration still drives the level for one cycle.
  function automatic logic [CNT_W-1:0] load_len(input logic [CNT_W-1:0] c);
    return (c == CNT_ZERO) ? CNT_ONE : c;
  endfunction

  assign cmd.cmd_ready = !full_s && !abort;
  assign push_s        = cmd.cmd_valid && cmd.cmd_ready;
  assign push_cmd_s    = '{level: cmd.cmd_level, cycles: cmd.cmd_cycles};

  cmd_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(seq_cmd_t))
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push_s),
    .push_data (push_cmd_s),
    .pop       (pop_s),
    .flush     (abort),
    .head_data (head_cmd_s),
    .count     (count_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Next state, next duration count and next output values.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    enable_s = enable_r;
    busy_s   = busy_r;
    done_s   = 1'b0;
    pop_s    = 1'b0;
    if (abort) begin
      state_s  = IDLE;
      cnt_s    = CNT_ZERO;
      enable_s = 1'b0;
      busy_s   = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          enable_s = 1'b0;
          busy_s   = 1'b0;
          if (start && !empty_s) begin
            pop_s    = 1'b1;
            state_s  = RUN;
            enable_s = head_cmd_s.level;
            busy_s   = 1'b1;
            cnt_s    = load_len(head_cmd_s.cycles);
          end else begin
            state_s = IDLE;
          end
        end
        RUN: begin
          if (cnt_r == CNT_ONE) begin
            if (!empty_s) begin
              // Chain straight into the next command with no gap cycle.
              pop_s    = 1'b1;
              enable_s = head_cmd_s.level;
              cnt_s    = load_len(head_cmd_s.cycles);
            end else begin
              state_s  = DONE;
              enable_s = 1'b0;
              busy_s   = 1'b0;
              done_s   = 1'b1;
              cnt_s    = CNT_ZERO;
            end
          end else begin
            cnt_s = cnt_r - CNT_ONE;
          end
        end
        DONE: begin
          state_s  = IDLE;
          enable_s = 1'b0;
          busy_s   = 1'b0;
        end
        default: begin
          state_s  = IDLE;
          cnt_s    = CNT_ZERO;
          enable_s = 1'b0;
          busy_s   = 1'b0;
        end
      endcase
    end
  end

  // State, counter and registered outputs; reset clears enable immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r  <= IDLE;
      cnt_r    <= CNT_ZERO;
      enable_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      enable_r <= enable_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign enable     = enable_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign fifo_count = count_s;

endmodule

// File: tb/tb_enable_seq.sv
// Self-checking bench for enable_seq: a queue-based playback model checked
// every cycle, plus directed traces with hand-computed expectations.
module tb_enable_seq;
  import enable_seq_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic       clk   = 1'b0;
  logic       rstn  = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       enable, busy, done;
  logic [2:0] fifo_count;

  enable_seq_if #(.CNT_W(CNT_W)) cmd_if ();

  enable_seq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cmd        (cmd_if.slave),
    .start      (start),
    .abort      (abort),
    .enable     (enable),
    .busy       (busy),
    .done       (done),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit level;
    int cycles;
  } mcmd_t;

  mcmd_t mq[$];
  bit    m_play;   // a command is being played
  bit    m_en;     // level on the bus
  int    m_left;   // cycles still to show for the current command
  bit    m_done;   // end-of-playback pulse

  task automatic m_clear();
    mq.delete();
    m_play = 1'b0;
    m_en   = 1'b0;
    m_left = 0;
    m_done = 1'b0;
  endtask

  task automatic m_load();
    mcmd_t c;
    c      = mq.pop_front();
    m_en   = c.level;
    m_left = (c.cycles == 0) ? 1 : c.cycles;
    m_play = 1'b1;
  endtask

  // One clock edge of the model, using the inputs held across that edge.
  task automatic m_update();
    bit    had_cmd;
    bit    acc;
    bit    was_done;
    mcmd_t nc;
    had_cmd = (mq.size() > 0);
    acc     = cmd_if.cmd_valid && (mq.size() < DEPTH) && !abort;
    if (abort) begin
      m_clear();
    end else begin
      was_done = m_done;
      m_done   = 1'b0;
      if (m_play) begin
        m_left--;
        if (m_left == 0) begin
          if (had_cmd) begin
            m_load();
          end else begin
            m_play = 1'b0;
            m_en   = 1'b0;
            m_done = 1'b1;
          end
        end
      end else if (start && had_cmd && !was_done) begin
        m_load();
      end
      if (acc) begin
        nc.level  = cmd_if.cmd_level;
        nc.cycles = int'(cmd_if.cmd_cycles);
        mq.push_back(nc);
      end
    end
  endtask

  // Compare DUT outputs against the model in the middle of every cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("enable", int'(enable), int'(m_en));
      chk("busy", int'(busy), int'(m_play));
      chk("done", int'(done), int'(m_done));
      chk("fifo_count", int'(fifo_count), mq.size());
      chk("cmd_ready", int'(cmd_if.cmd_ready), int'((mq.size() < DEPTH) && !abort));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    if (rstn) m_update();
    #2;
  endtask

  task automatic push(input bit lv, input int cy);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_level  = lv;
    cmd_if.cmd_cycles = CNT_W'(cy);
    step();
    cmd_if.cmd_valid  = 1'b0;
  endtask

  bit tr_en [16];
  bit tr_dn [16];
  bit tr_bz [16];

  // Pulse start on the first edge and record outputs of cycles N+1..N+n.
  task automatic play_trace(input int n);
    start = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      start = 1'b0;
      tr_en[i] = enable;
      tr_dn[i] = done;
      tr_bz[i] = busy;
    end
  endtask

  bit e2_en [5]  = '{1, 1, 1, 0, 0};
  bit e2_dn [5]  = '{0, 0, 0, 1, 0};
  bit e2_bz [5]  = '{1, 1, 1, 0, 0};
  bit e3_en [10] = '{1, 1, 0, 1, 1, 1, 1, 1, 0, 0};
  bit e3_dn [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
  bit e4_en [7]  = '{1, 0, 0, 1, 0, 0, 0};
  bit e4_dn [7]  = '{0, 0, 0, 0, 0, 1, 0};
  bit e4_bz [7]  = '{1, 1, 1, 1, 1, 0, 0};

  initial begin
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_level  = 1'b0;
    cmd_if.cmd_cycles = '0;
    m_clear();

    // Reset then idle
    rstn = 1'b0;
    step();
    chk_on = 1'b1;
    step();
    step();
    chk("rst_enable", int'(enable), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(fifo_count), 0);
    rstn = 1'b1;
    #1;
    chk("rst_ready", int'(cmd_if.cmd_ready), 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("empty_start_busy", int'(busy), 0);
    step();
    chk("empty_start_done", int'(done), 0);

    // Single command {1,3}
    push(1'b1, 3);
    play_trace(5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("single_en[%0d]", i), int'(tr_en[i]), int'(e2_en[i]));
      chk($sformatf("single_done[%0d]", i), int'(tr_dn[i]), int'(e2_dn[i]));
      chk($sformatf("single_busy[%0d]", i), int'(tr_bz[i]), int'(e2_bz[i]));
    end

    // Back-to-back pattern
    push(1'b1, 2);
    push(1'b0, 1);
    push(1'b1, 5);
    play_trace(10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("b2b_en[%0d]", i), int'(tr_en[i]), int'(e3_en[i]));
      chk($sformatf("b2b_done[%0d]", i), int'(tr_dn[i]), int'(e3_dn[i]));
    end

    // FIFO full and zero-length commands
    push(1'b1, 0);
    push(1'b0, 2);
    push(1'b1, 1);
    push(1'b0, 0);
    #1;
    chk("full_ready", int'(cmd_if.cmd_ready), 0);
    chk("full_count", int'(fifo_count), 4);
    push(1'b1, 7);
    chk("full_reject_count", int'(fifo_count), 4);
    play_trace(7);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("zero_en[%0d]", i), int'(tr_en[i]), int'(e4_en[i]));
      chk($sformatf("zero_done[%0d]", i), int'(tr_dn[i]), int'(e4_dn[i]));
      chk($sformatf("zero_busy[%0d]", i), int'(tr_bz[i]), int'(e4_bz[i]));
    end

    // Abort mid-run in the 4th RUN cycle, with a push attempted alongside
    push(1'b1, 10);
    push(1'b0, 4);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    abort = 1'b1;
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_level  = 1'b1;
    cmd_if.cmd_cycles = CNT_W'(3);
    #1;
    chk("abort_ready", int'(cmd_if.cmd_ready), 0);
    chk("abort_pre_en", int'(enable), 1);
    step();
    abort = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    chk("abort_en", int'(enable), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_count", int'(fifo_count), 0);
    chk("abort_done0", int'(done), 0);
    step();
    chk("abort_done1", int'(done), 0);

    // Asynchronous reset mid-run
    push(1'b1, 6);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    #1;
    chk("async_pre_en", int'(enable), 1);
    push(1'b0, 2);
    #1;
    rstn = 1'b0;
    m_clear();
    #1;
    chk("async_en", int'(enable), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_count", int'(fifo_count), 0);
    step();
    rstn = 1'b1;
    step();
    chk("post_rst_count", int'(fifo_count), 0);
    chk("post_rst_busy", int'(busy), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("post_rst_start_busy", int'(busy), 0);
    chk("post_rst_start_en", int'(enable), 0);
    step();

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/enable_seq.md
Name: enable_seq

Overview:
- Synthesizable enable-pattern sequencer that sits directly upstream of the bus DUT.
- Drives the bus `enable` signal from a queued list of {level, duration} commands, replacing hand-timed delay wiggling in benches.
- Commands arrive over a valid/ready port into a small internal FIFO.
- Playback is started explicitly and ends with a one-cycle done pulse.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, >=2)
- CNT_W, 16, width of the per-command duration field

Ports:
- clk  input  1  system clock, all logic on rising edge
- rstn  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  FIFO can accept a command
- cmd_level  input  1  enable level to drive for this command
- cmd_cycles  input  CNT_W  number of cycles to hold the level; 0 treated as 1
- start  input  1  begin playback of queued commands
- abort  input  1  stop playback and flush the FIFO
- enable  output  1  drives the bus enable (to `busIf.enable`)
- busy  output  1  playback in progress
- done  output  1  one-cycle pulse at normal end of playback
- fifo_count  output  $clog2(DEPTH+1)  number of queued commands

Behaviour:
- Clock is `clk`. Reset is `rstn`, asynchronous, active-low; the polarity and synchronicity are fixed.
- Reset values:
  - enable=0, busy=0, done=0, fifo_count=0.
  - cmd_ready=1 once rstn is high.
  - State is IDLE and the counter is 0.
  - Reset asserted mid-playback drops enable to 0 immediately (asynchronously) and discards all queued commands.
- Push:
  - A command is accepted on an edge where cmd_valid && cmd_ready.
  - cmd_ready = (fifo_count < DEPTH) && !abort.
  - There is no full-bypass: a pop and a push in the same cycle while full is not allowed, because ready is already low.
  - Simultaneous push and pop while not full leaves fifo_count unchanged.
- State machine {IDLE, RUN, DONE}, registered outputs:
  - IDLE: enable=0, busy=0.
    - start && fifo_count>0 at edge N: pop the head, and at edge N the registers take enable=level, cnt=max(cycles,1), state=RUN.
    - enable shows the new level in cycle N+1, i.e. one cycle of latency from start.
    - start with an empty FIFO is ignored; no done pulse.
  - RUN: busy=1, enable holds the command level. cnt decrements each cycle.
    - When cnt==1 and the FIFO is non-empty, pop the next command at that edge. There is no gap cycle between commands, so enable transitions directly.
    - When cnt==1 and the FIFO is empty, go to DONE with enable=0.
    - Commands pushed during RUN extend the playback if they arrive before the last cycle of the current command.
    - start during RUN is ignored.
  - DONE: exactly one cycle, done=1, busy=0, enable=0, then IDLE.
- Each command drives enable for exactly max(cmd_cycles,1) cycles.
- cmd_cycles counts at full CNT_W width with no wrap: the maximum duration is 2^CNT_W-1 cycles.
- Abort:
  - Abort in any state: at the next edge go to IDLE, enable=0, busy=0, FIFO flushed (fifo_count=0).
  - No done pulse is produced.
  - Abort has priority over start, over the internal pop, and over a push in the same cycle; the push is dropped because ready is low.
- FIFO pointers wrap modulo DEPTH. fifo_count is registered and is never above DEPTH.

Decomposition:
- Shared package `enable_seq_pkg`:
  - state enum `seq_state_t` {IDLE, RUN, DONE}.
  - packed struct `seq_cmd_t` {level, cycles[CNT_W]}.
- One natural sub-module: `cmd_fifo`.
  - Parameterized on DEPTH and the seq_cmd_t width.
  - Provides push/pop/flush, count output and full/empty.
  - Data is read from the head with no latency.
- The top level holds the FSM, the duration counter and the output registers.

Test Plan:
- Reset then idle: rstn low for 3 cycles -> enable=0, busy=0, done=0, fifo_count=0, cmd_ready=1 once released; start with an empty FIFO -> no change.
- Single command: push {1,3}, start at edge N -> enable=1 in cycles N+1..N+3, done=1 in cycle N+4, enable=0 thereafter, busy high for cycles N+1..N+3.
- Back-to-back pattern matching a typical bench: push {1,2},{0,1},{1,5} then start -> enable sequence 1,1,0,1,1,1,1,1 with no gaps, then one done pulse.
- FIFO full and zero-length: push 4 commands with DEPTH=4 -> cmd_ready=0 and a 5th valid is not accepted; a command with cycles=0 holds its level for exactly 1 cycle.
- Abort mid-run: push {1,10},{0,4}, start, assert abort in the 4th RUN cycle -> next cycle enable=0, busy=0, fifo_count=0, no done pulse; a push in the abort cycle is not accepted.
- Async reset mid-run: drop rstn between edges during RUN with enable=1 -> enable falls without waiting for clk; after release the FIFO is empty and state is IDLE.
